mavg_channel_scheduler: RTL



---
 rtl/mavg_sched_pkg.sv | 35 +++
 rtl/mavg_history_bank.sv | 54 +++++
 rtl/mavg_channel_scheduler.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mavg_sched_pkg.sv
// Shared types, defaults and the round-robin pick helper for the moving-average scheduler.
package mavg_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_e;

  localparam int DEF_NCH      = 4;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_WINDOW   = 16;
  localparam int DEF_LOG2_WIN = 4;
  localparam int MAX_NCH      = 8;

  // First set bit of valid at or above ptr, wrapping modulo nch; 0 when none set.
  function automatic logic [2:0] rr_pick(input logic [MAX_NCH-1:0] valid,
                                         input logic [2:0]         ptr,
                                         input int                 nch);
    logic [2:0] g;
    logic       found;
    int         idx;
    g     = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_NCH; i++) begin
      idx = (int'(ptr) + i) % nch;
      if (i < nch && !found && valid[idx[2:0]]) begin
        g     = idx[2:0];
        found = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/mavg_history_bank.sv
// Per-channel sample history with write pointer; the read port returns the oldest sample.
// With MAVG_SCHED_FLUSH_EN defined, a clear port wipes one channel's history and pointer.
module mavg_history_bank
  import mavg_sched_pkg::*;
#(
  parameter int NCH      = DEF_NCH,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WINDOW   = DEF_WINDOW,
  parameter int LOG2_WIN = DEF_LOG2_WIN,
  parameter int CH_W     = $clog2(DEF_NCH)
) (
  input  logic              system1000,
  input  logic              system1000_rstn,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [DATA_W-1:0] wr_data
`ifdef MAVG_SCHED_FLUSH_EN
  ,
  input  logic              clr_en,
  input  logic [CH_W-1:0]   clr_ch
`endif
);

  logic [DATA_W-1:0] head [NCH];

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [WINDOW-1:0][DATA_W-1:0] hist_q;
    logic [LOG2_WIN-1:0]           wptr_q;

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
      if (!system1000_rstn) begin
        hist_q <= '0;
        wptr_q <= '0;
      end
`ifdef MAVG_SCHED_FLUSH_EN
      else if (clr_en && clr_ch == CH_W'(c)) begin
        hist_q <= '0;
        wptr_q <= '0;
      end
`endif
      else if (wr_en && wr_ch == CH_W'(c)) begin
        hist_q[wptr_q] <= wr_data;
        wptr_q         <= wptr_q + 1'b1;   // WINDOW is a power of two: natural wrap
      end
    end

    assign head[c] = hist_q[wptr_q];
  end

  assign rd_data = head[rd_ch];

endmodule

// File: rtl/mavg_channel_scheduler.sv
// Round-robin time-multiplexed moving-average engine: IDLE grants, CALC updates, OUT hands off.
// Optional per-channel flush port when MAVG_SCHED_FLUSH_EN is defined.
module mavg_channel_scheduler
  import mavg_sched_pkg::*;
#(
  parameter int NCH      = DEF_NCH,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WINDOW   = DEF_WINDOW,
  parameter int LOG2_WIN = DEF_LOG2_WIN,
  parameter int TOTAL_W  = DEF_DATA_W + DEF_LOG2_WIN
) (
  input  logic                    system1000,
  input  logic                    system1000_rstn,
`ifdef MAVG_SCHED_FLUSH_EN
  input  logic [NCH-1:0]          flush,
`endif
  input  logic [NCH-1:0]          req_valid,
  input  logic [NCH*DATA_W-1:0]   req_sample,
  output logic [NCH-1:0]          req_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(NCH)-1:0]  out_chan,
  output logic [DATA_W-1:0]       out_avg,
  output logic [TOTAL_W-1:0]      out_total
);

  localparam int CH_W = $clog2(NCH);

  state_e                      state_q;
  logic [CH_W-1:0]             ch_q, rr_ptr_q, grant, rr_next;
  logic [DATA_W-1:0]           smp_q, oldest;
  logic [NCH-1:0][TOTAL_W-1:0] total_q;
  logic [TOTAL_W-1:0]          smp_ext, old_ext, new_total;
  logic [MAX_NCH-1:0]          vld_ext;
  logic [2:0]                  pick_raw;
  logic                        flush_go;
  logic                        take;

  assign vld_ext  = MAX_NCH'(req_valid);
  assign pick_raw = rr_pick(vld_ext, 3'(rr_ptr_q), NCH);
  assign grant    = pick_raw[CH_W-1:0];
  assign rr_next  = (ch_q == CH_W'(NCH - 1)) ? '0 : ch_q + 1'b1;

`ifdef MAVG_SCHED_FLUSH_EN
  logic [CH_W-1:0] flush_ch;
  always_comb begin
    flush_ch = '0;
    for (int c = NCH - 1; c >= 0; c--)
      if (flush[c]) flush_ch = CH_W'(c);
  end
  assign flush_go = (state_q == IDLE) && |flush;
`else
  assign flush_go = 1'b0;
`endif

  assign take = (state_q == IDLE) && !flush_go && |req_valid;

  always_comb begin
    req_ready = '0;
    if (take) req_ready[grant] = 1'b1;
  end

  mavg_history_bank #(
    .NCH(NCH), .DATA_W(DATA_W), .WINDOW(WINDOW), .LOG2_WIN(LOG2_WIN), .CH_W(CH_W)
  ) u_hist (
    .system1000      (system1000),
    .system1000_rstn (system1000_rstn),
    .rd_ch           (ch_q),
    .rd_data         (oldest),
    .wr_en           (state_q == CALC),
    .wr_ch           (ch_q),
    .wr_data         (smp_q)
`ifdef MAVG_SCHED_FLUSH_EN
    ,
    .clr_en          (flush_go),
    .clr_ch          (flush_ch)
`endif
  );

  assign smp_ext   = {{(TOTAL_W-DATA_W){smp_q[DATA_W-1]}}, smp_q};
  assign old_ext   = {{(TOTAL_W-DATA_W){oldest[DATA_W-1]}}, oldest};
  assign new_total = total_q[ch_q] + smp_ext - old_ext;

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      total_q <= '0;
    end else if (state_q == CALC) begin
      total_q[ch_q] <= new_total;
    end
`ifdef MAVG_SCHED_FLUSH_EN
    else if (flush_go) begin
      total_q[flush_ch] <= '0;
    end
`endif
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      smp_q     <= '0;
      rr_ptr_q  <= '0;
      out_valid <= 1'b0;
      out_chan  <= '0;
      out_avg   <= '0;
      out_total <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (take) begin
          ch_q    <= grant;
          smp_q   <= req_sample[grant*DATA_W +: DATA_W];
          state_q <= CALC;
        end
        CALC: begin
          out_total <= new_total;
          // Arithmetic shift then truncate to DATA_W is exactly this bit slice.
          out_avg   <= new_total[LOG2_WIN +: DATA_W];
          out_chan  <= ch_q;
          out_valid <= 1'b1;
          state_q   <= OUT;
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          rr_ptr_q  <= rr_next;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
